uart_receiver: RTL and testbench



---
 rtl/uart_receiver.sv | 113 +++++++++++
 tb/tb_uart_receiver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 8 clocks per bit, mid-bit sampling.
// Two-flop synchronized input; single-cycle valid and frame-error pulses.
module uart_receiver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t     r_state, w_state_n;
  logic       r_sync1, r_rx_s;
  logic [2:0] r_cnt, w_cnt_n;
  logic [2:0] r_idx, w_idx_n;
  logic [7:0] r_shift, w_shift_n;
  logic [7:0] r_data, w_data_n;
  logic       r_valid, w_valid_n;
  logic       r_ferr, w_ferr_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_ferr  <= w_ferr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 3'd1;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_n = 3'd0;
        w_idx_n = 3'd0;
        if (!r_rx_s) w_state_n = S_START;
      end
      // Re-check the line mid-way through the start bit
      S_START: begin
        if (r_cnt == 3'd3) begin
          w_cnt_n   = 3'd0;
          w_state_n = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == 3'd7) begin
          w_shift_n = {r_rx_s, r_shift[7:1]};
          w_idx_n   = r_idx + 3'd1;
          w_cnt_n   = 3'd0;
          if (r_idx == 3'd7) w_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == 3'd7) begin
          w_cnt_n = 3'd0;
          if (r_rx_s) begin
            w_data_n  = r_shift;
            w_valid_n = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_ferr_n  = 1'b1;
            w_state_n = S_BREAK;
          end
        end
      end
      // Hold off until the line recovers so a break is not a new start
      S_BREAK: begin
        w_cnt_n = 3'd0;
        if (r_rx_s) w_state_n = S_IDLE;
      end
      default: begin
        w_cnt_n   = 3'd0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign frame_error = r_ferr;
  assign rx_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized frames against a byte-queue reference.
// Edge-accurate checks of pulse timing, glitch, break and reset.
module tb_uart_receiver;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       rx_busy;

  int tests;
  int fails;
  int cyc;
  int both;

  logic [7:0] vdata[$];
  int         vcyc[$];
  int         ecyc[$];
  logic [7:0] expq[$];

  uart_receiver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial both = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        vdata.push_back(rx_data);
        vcyc.push_back(cyc);
      end
      if (frame_error) ecyc.push_back(cyc);
      if (rx_valid && frame_error) both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx = 1'b1;
    end
  endtask

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Start bit of slen clocks, 8 data bits LSB first, stop of stlen clocks
  task automatic send_frame(input logic [7:0] d, input int slen,
                            input int stlen, input logic stv,
                            output int e0);
    logic [9:0] bits;
    int n;
    bits = {stv, d, 1'b0};
    e0 = 0;
    for (int b = 0; b < 10; b++) begin
      n = (b == 0) ? slen : ((b == 9) ? stlen : 8);
      for (int k = 0; k < n; k++) begin
        @(posedge clk);
        #1 rx = bits[b];
        if (b == 0 && k == 0) e0 = cyc + 1;
      end
    end
  endtask

  initial begin
    int e0, e1, g0, r, nv, base;
    logic [7:0] d;
    tests = 0;
    fails = 0;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(rx_data), 32'h00);
    chk("reset_valid", 32'(rx_valid), 32'h0);
    chk("reset_ferr", 32'(frame_error), 32'h0);
    chk("reset_busy", 32'(rx_busy), 32'h0);
    rst_n = 1'b1;
    idle(5);

    send_frame(8'hA5, 8, 8, 1'b1, e0);
    idle(10);
    chk("a5_count", 32'(vdata.size()), 32'd1);
    chk("a5_data", 32'(vdata[0]), 32'hA5);
    chk("a5_time", 32'(vcyc[0]), 32'(e0 + 78));
    chk("a5_ferr", 32'(ecyc.size()), 32'd0);
    chk("a5_busy", 32'(rx_busy), 32'h0);

    send_frame(8'h00, 8, 8, 1'b1, e0);
    send_frame(8'hFF, 8, 8, 1'b1, e1);
    idle(10);
    chk("b2b_count", 32'(vdata.size()), 32'd3);
    chk("b2b_data0", 32'(vdata[1]), 32'h00);
    chk("b2b_data1", 32'(vdata[2]), 32'hFF);
    chk("b2b_gap", 32'(vcyc[2] - vcyc[1]), 32'd80);
    chk("b2b_time", 32'(vcyc[1]), 32'(e0 + 78));

    @(posedge clk);
    #1 rx = 1'b0;
    g0 = cyc + 1;
    @(posedge clk);
    #1 rx = 1'b0;
    @(posedge clk);
    #1 rx = 1'b1;
    wait_cyc(g0 + 2);
    chk("glitch_busy_e2", 32'(rx_busy), 32'h1);
    wait_cyc(g0 + 5);
    chk("glitch_busy_e5", 32'(rx_busy), 32'h1);
    wait_cyc(g0 + 6);
    chk("glitch_busy_e6", 32'(rx_busy), 32'h0);
    idle(10);
    chk("glitch_valid", 32'(vdata.size()), 32'd3);
    chk("glitch_ferr", 32'(ecyc.size()), 32'd0);
    chk("glitch_data", 32'(rx_data), 32'hFF);

    send_frame(8'h3C, 8, 20, 1'b0, e0);
    @(posedge clk);
    #1 rx = 1'b1;
    r = cyc + 1;
    wait_cyc(r + 1);
    chk("brk_busy_hold", 32'(rx_busy), 32'h1);
    wait_cyc(r + 2);
    chk("brk_busy_rel", 32'(rx_busy), 32'h0);
    idle(20);
    chk("brk_ferr_cnt", 32'(ecyc.size()), 32'd1);
    chk("brk_ferr_time", 32'(ecyc[0]), 32'(e0 + 78));
    chk("brk_no_valid", 32'(vdata.size()), 32'd3);
    chk("brk_data", 32'(rx_data), 32'hFF);
    chk("brk_idle_busy", 32'(rx_busy), 32'h0);

    nv = vdata.size();
    d  = 8'hC3;
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < ((b == 5) ? 4 : 8); k++) begin
        @(posedge clk);
        #1 rx = (b == 0) ? 1'b0 : d[b-1];
      end
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_data", 32'(rx_data), 32'h00);
    chk("rst_mid_valid", 32'(rx_valid), 32'h0);
    chk("rst_mid_ferr", 32'(frame_error), 32'h0);
    chk("rst_mid_busy", 32'(rx_busy), 32'h0);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold_busy", 32'(rx_busy), 32'h0);
    rst_n = 1'b1;
    idle(5);
    send_frame(8'h5A, 8, 8, 1'b1, e0);
    idle(10);
    chk("rst_after_cnt", 32'(vdata.size()), 32'(nv + 1));
    chk("rst_after_data", 32'(vdata[nv]), 32'h5A);
    chk("rst_after_time", 32'(vcyc[nv]), 32'(e0 + 78));

    nv = vdata.size();
    send_frame(8'h96, 9, 8, 1'b1, e0);
    idle(3);
    send_frame(8'h01, 9, 8, 1'b1, e1);
    idle(10);
    chk("lb_count", 32'(vdata.size()), 32'(nv + 2));
    chk("lb_data0", 32'(vdata[nv]), 32'h96);
    chk("lb_data1", 32'(vdata[nv+1]), 32'h01);
    chk("lb_time1", 32'(vcyc[nv+1]), 32'(e1 + 78));
    chk("lb_ferr", 32'(ecyc.size()), 32'd1);

    base = vdata.size();
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      send_frame(d, 8 + int'($urandom_range(0, 1)), 8, 1'b1, e0);
      expq.push_back(d);
      idle(int'($urandom_range(0, 4)));
    end
    idle(12);
    chk("rnd_count", 32'(vdata.size()), 32'(base + expq.size()));
    for (int i = 0; i < expq.size() && base + i < vdata.size(); i++)
      chk($sformatf("rnd_data%0d", i), 32'(vdata[base+i]), 32'(expq[i]));
    chk("rnd_ferr", 32'(ecyc.size()), 32'd1);
    chk("never_both", 32'(both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
